uart_rx_framer: RTL
===================

// Module: uart_rx_framer
// PURPOSE
//  FSM-based synchronous serial frame receiver; successor to the plain shift-register RX shifter.
//  Adds oversampled bit timing, optional parity, LSB/MSB-first order and framing/parity error reporting.
//  Sits inside the FPGA or at an inter-FPGA pin, paired with a TX shifter on the same clock source.
// PARAMETERS
//  START_BITS      1  start bit count (>=1), line level 0
//  DATA_BITS       8  payload bits (>=1)
//  STOP_BITS       2  stop bit count (>=1), line level 1
//  PARITY_MODE     0  0 none, 1 even, 2 odd; one parity bit between data and stop
//  MSB_FIRST       1  1 first data bit lands in rx_data[DATA_BITS-1]; 0 in rx_data[0]
//  CLKS_PER_BIT    1  clk cycles per bit (>=1); 1 = one bit per clock
//  SYNCHRONIZE_RXD 0  1 inserts 2-flop synchronizer on rxd (+2 cycles latency)
// PORTS
//  clk         in   1          clock
//  nrst        in   1          reset, synchronous, active-low
//  rxd         in   1          serial line, idle high
//  rx_data     out  DATA_BITS  last received payload
//  rx_valid    out  1          1-cycle strobe: frame received without error
//  frame_err   out  1          1-cycle strobe: a stop bit sampled 0
//  parity_err  out  1          1-cycle strobe: parity mismatch, stop bits good
//  err_cnt     out  16         saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, rx_data=0, rx_valid=frame_err=parity_err=0, err_cnt=0, timers cleared. Reset mid-frame discards it.
//  - Bit timer counts 0..CLKS_PER_BIT-1; sample point at count CLKS_PER_BIT/2 (integer). CLKS_PER_BIT=1: every clk is a sample.
//  - States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//  - IDLE: on rxd==0 restart timer, go START; the first start sample is taken at that bit's sample point.
//  - START: START_BITS samples must all be 0; any 1 -> IDLE, no strobe (glitch/false start).
//  - DATA: DATA_BITS samples shifted per MSB_FIRST; PARITY_MODE!=0 -> PARITY, else STOP.
//  - PARITY: 1 sample; mismatch vs XOR of data (even) / XNOR (odd) latched as pending parity error.
//  - STOP: STOP_BITS samples must be 1; first 0 -> frame_err, go WAIT_IDLE.
//  - Last stop sample good: rx_data updated; rx_valid, or parity_err if pending, on the next cycle; -> IDLE.
//  - Frame errors leave rx_data unchanged. Parity errors still load rx_data.
//  - WAIT_IDLE: hold until a sample reads 1 -> IDLE; a stuck-low line yields exactly one frame_err.
//  - Latency, CLKS_PER_BIT=1, no sync: strobe 1 clk after last stop bit; back-to-back frames, no gap needed.
//  - At most one of rx_valid/frame_err/parity_err high in any cycle.
//  - Bit counters sized $clog2(max(START_BITS,DATA_BITS,STOP_BITS)+1); timer $clog2(CLKS_PER_BIT+1).
// CONFIGURATION
//  UART_RX_FRAMER_ERR_CNT_EN defined:
//    err_cnt +1 per frame_err or parity_err strobe; saturates at 16'hFFFF; cleared only by reset.
//  Not defined: err_cnt tied to 0, no counter logic.
// STRUCTURE
//  Package uart_rx_framer_pkg: state enum, PARITY_NONE/EVEN/ODD constants, err_cnt width localparam.
//  Sub-module: existing `delay` (LENGTH 2, WIDTH 1) as the rxd synchronizer.
//  Bit timer and FSM stay inline.
// TESTING
//  - 8N2, CLKS_PER_BIT=1: frame data 8'hA5 -> rx_valid 1 clk after last stop, rx_data=8'hA5.
//  - Continuous stream 8'h01, 8'hFF, 8'h80, no gaps -> three rx_valid strobes, spaced 11 clks, correct data.
//  - CLKS_PER_BIT=4: 1-clk low glitch on idle line -> no strobe. Frame 8'h3C -> rx_valid, rx_data=8'h3C.
//  - PARITY_MODE=1: frame 8'h07 with parity bit 0 -> parity_err, rx_data=8'h07.
//    Same frame, parity bit 1 -> rx_valid.
//  - rxd held 0 for 40 clks -> exactly one frame_err, no other strobe. Release -> next frame received normally.
//  - UART_RX_FRAMER_ERR_CNT_EN defined: 3 bad frames -> err_cnt=3.
//    nrst low mid-frame -> all outputs 0, following frame received correctly.

Source files
------------

// File: rtl/uart_rx_framer_pkg.sv
// Shared types and constants for the uart_rx_framer receiver.
package uart_rx_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   localparam int ERR_CNT_W = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length pipeline delay; used as the rxd metastability synchronizer.
module delay #(
   parameter int LENGTH = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [LENGTH];
   logic [WIDTH-1:0] stage_d [LENGTH];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < LENGTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // No reset on purpose: the stages only carry the line level and flush within LENGTH clocks.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   assign q = stage_q[LENGTH-1];

endmodule

// File: rtl/uart_rx_framer.sv
// Oversampled serial frame receiver with optional parity and error strobes.
// Define UART_RX_FRAMER_ERR_CNT_EN to build the saturating err_cnt counter.
module uart_rx_framer
   import uart_rx_framer_pkg::*;
#(
   parameter int START_BITS      = 1,
   parameter int DATA_BITS       = 8,
   parameter int STOP_BITS       = 2,
   parameter int PARITY_MODE     = 0,
   parameter int MSB_FIRST       = 1,
   parameter int CLKS_PER_BIT    = 1,
   parameter int SYNCHRONIZE_RXD = 0
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic [15:0]          err_cnt
);

   localparam int BIT_CNT_W = $clog2(max3(START_BITS, DATA_BITS, STOP_BITS) + 1);
   localparam int TMR_W     = $clog2(CLKS_PER_BIT + 1);

   localparam logic [TMR_W-1:0]     SAMPLE_PT  = TMR_W'(CLKS_PER_BIT / 2);
   localparam logic [TMR_W-1:0]     TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_CNT_W-1:0] START_LAST = BIT_CNT_W'(START_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] DATA_LAST  = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] STOP_LAST  = BIT_CNT_W'(STOP_BITS - 1);

   logic rxd_s;

   generate
      if (SYNCHRONIZE_RXD != 0) begin : g_sync
         delay #(.LENGTH(2), .WIDTH(1)) u_sync (.clk(clk), .d(rxd), .q(rxd_s));
      end else begin : g_nosync
         assign rxd_s = rxd;
      end
   endgenerate

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d, cnt_eff_s;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   par_pend_q, par_pend_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   parity_err_q, parity_err_d;
   logic                   sample_s;
   logic                   par_exp_s;

   // The idle cycle that sees the falling edge is count 0 of the first start bit.
   assign cnt_eff_s = (state_q == ST_IDLE) ? '0 : timer_q;
   assign sample_s  = (cnt_eff_s == SAMPLE_PT);
   assign par_exp_s = (PARITY_MODE == PARITY_ODD) ? ~(^shift_q) : (^shift_q);

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      par_pend_d   = par_pend_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      timer_d      = (cnt_eff_s == TMR_LAST) ? '0 : cnt_eff_s + TMR_W'(1);

      case (state_q)
         ST_IDLE: begin
            par_pend_d = 1'b0;
            bit_cnt_d  = '0;
            if (!rxd_s) begin
               state_d = ST_START;
               if (sample_s) begin
                  if (START_LAST == '0) begin
                     state_d = ST_DATA;
                  end else begin
                     bit_cnt_d = BIT_CNT_W'(1);
                  end
               end else begin
                  bit_cnt_d = '0;
               end
            end else begin
               timer_d = '0;
            end
         end
         ST_START: begin
            if (sample_s) begin
               if (rxd_s) begin
                  state_d = ST_IDLE;
               end else if (bit_cnt_q == START_LAST) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (sample_s) begin
               if (MSB_FIRST != 0) begin
                  shift_d = DATA_BITS'({shift_q, rxd_s});
               end else begin
                  shift_d = DATA_BITS'({rxd_s, shift_q} >> 1);
               end
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (sample_s) begin
               par_pend_d = (rxd_s != par_exp_s);
               state_d    = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (sample_s) begin
               if (!rxd_s) begin
                  frame_err_d = 1'b1;
                  bit_cnt_d   = '0;
                  state_d     = ST_WAIT_IDLE;
               end else if (bit_cnt_q == STOP_LAST) begin
                  rx_data_d    = shift_q;
                  rx_valid_d   = !par_pend_q;
                  parity_err_d = par_pend_q;
                  bit_cnt_d    = '0;
                  state_d      = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            if (sample_s && rxd_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Receiver state, timers and output strobe registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         par_pend_q   <= 1'b0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         par_pend_q   <= par_pend_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;

`ifdef UART_RX_FRAMER_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      if ((frame_err_d || parity_err_d) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Saturating error counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 16'h0000;
`endif

endmodule
